// File: rtl/pvci_arb2.sv
// Two-requester arbiter/sequencer for the 8-bit PVCI register port: one strobe per access,
// read data sampled WAIT_CYCLES after the strobe. Define PVCI_ARB_FIXED_PRIO_EN for fixed priority.
module pvci_arb2 #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rd,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wd,
    output logic [1:0]  req_ack,
    output logic [7:0]  req_rdata,
    output logic [7:0]  pvci_addr,
    output logic [7:0]  pvci_wd,
    output logic        pvci_valid,
    output logic        pvci_rd,
    input  logic [7:0]  pvci_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wd_q, wd_d;
    logic        rd_q, rd_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sel;

`ifdef PVCI_ARB_FIXED_PRIO_EN
    // Requester 0 always wins; requester 1 only when requester 0 is idle.
    always_comb begin
        sel = ~req_valid[0];
    end
`else
    logic last_q, last_d;

    // On contention the requester not granted last time wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            sel = ~last_q;
        end else begin
            sel = req_valid[1];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
`ifndef PVCI_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    grant_d = sel;
                    addr_d  = req_addr[{sel, 3'b000} +: 8];
                    wd_d    = req_wd[{sel, 3'b000} +: 8];
                    rd_d    = req_rd[sel];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'(WAIT_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (rd_q) begin
                        rdata_d = pvci_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
`ifndef PVCI_ARB_FIXED_PRIO_EN
                last_d  = grant_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h00;
            wd_q    <= 8'h00;
            rd_q    <= 1'b0;
            rdata_q <= 8'h00;
`ifndef PVCI_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
`ifndef PVCI_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    // Outputs decode registered state only, so reset drops the strobe immediately.
    assign pvci_valid = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign req_ack    = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign pvci_addr  = addr_q;
    assign pvci_wd    = wd_q;
    assign pvci_rd    = rd_q;
    assign req_rdata  = rdata_q;

endmodule
